// File: rtl/p23_alu_exec_pkg.sv
// p23_alu_exec_pkg: ALU control codes, exec-unit state encodings and shared widths
package p23_alu_exec_pkg;
  localparam int XLEN = 32;
  localparam int ALU_CTRL_WIDTH = 5;
  localparam int ALU_EXEC_STATE_WIDTH = 2;
  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    ALU_CTRL_ADD_ADDI, ALU_CTRL_AUIPC, ALU_CTRL_SUB, ALU_CTRL_LUI,
    ALU_CTRL_XOR, ALU_CTRL_OR, ALU_CTRL_AND, ALU_CTRL_SLT, ALU_CTRL_SLTU,
    ALU_CTRL_SLL, ALU_CTRL_SRL, ALU_CTRL_SRA,
    ALU_CTRL_MIN, ALU_CTRL_MAX, ALU_CTRL_MINU, ALU_CTRL_MAXU,
    ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_BLT, ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU
  } alu_ctrl_e;
  typedef enum logic [ALU_EXEC_STATE_WIDTH-1:0] {
    ALU_EXEC_IDLE, ALU_EXEC_SHIFT, ALU_EXEC_DONE
  } alu_exec_state_e;
  function automatic logic is_shift(input logic [ALU_CTRL_WIDTH-1:0] c);
    return c == ALU_CTRL_SLL || c == ALU_CTRL_SRL || c == ALU_CTRL_SRA;
  endfunction
endpackage

// File: rtl/p23_alu_exec_if.sv
// p23_alu_exec_if: request/response handshake bundle between control FSM and ALU exec unit
interface p23_alu_exec_if;
  import p23_alu_exec_pkg::*;
  logic                      req_valid;
  logic                      req_ready;
  logic [ALU_CTRL_WIDTH-1:0] ALUControl;
  logic [XLEN-1:0]           a;
  logic [XLEN-1:0]           b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [XLEN-1:0]           result;
  logic                      cond;
  modport master (output req_valid, ALUControl, a, b, rsp_ready,
                  input  req_ready, rsp_valid, result, cond);
  modport slave  (input  req_valid, ALUControl, a, b, rsp_ready,
                  output req_ready, rsp_valid, result, cond);
endinterface

// File: rtl/p23_alu_cmp.sv
// p23_alu_cmp: shared subtractor giving a-b plus signed/unsigned less-than and equality
module p23_alu_cmp
  import p23_alu_exec_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_diff,
  output logic            o_lt_s,
  output logic            o_lt_u,
  output logic            o_eq
);
  logic [XLEN:0] w_sub;
  assign w_sub  = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff = w_sub[XLEN-1:0];
  assign o_lt_u = w_sub[XLEN];
  // with differing signs the negative operand is the smaller one
  assign o_lt_s = (i_a[XLEN-1] ^ i_b[XLEN-1]) ? i_a[XLEN-1] : w_sub[XLEN];
  assign o_eq   = ~|w_sub[XLEN-1:0];
endmodule

// File: rtl/p23_alu_exec.sv
// p23_alu_exec: multicycle ALU execute unit with 1 bit/cycle shifts;
// define ALU_EXEC_BARREL_SHIFT_EN for a combinational barrel shifter (all ops single-cycle).
module p23_alu_exec
  import p23_alu_exec_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  p23_alu_exec_if.slave    bus
);
  alu_exec_state_e r_state, w_next;
  logic [XLEN-1:0] r_result, w_res, w_diff, w_hold_res;
  logic            r_cond, w_cond, w_lt_s, w_lt_u, w_eq;
  logic            w_accept, w_long, w_last;
  logic [4:0]      w_shamt;

  p23_alu_cmp u_cmp (
    .i_a(bus.a), .i_b(bus.b), .o_diff(w_diff),
    .o_lt_s(w_lt_s), .o_lt_u(w_lt_u), .o_eq(w_eq)
  );

  assign w_shamt       = bus.b[4:0];
  assign w_accept      = bus.req_valid && r_state == ALU_EXEC_IDLE;
  assign bus.req_ready = r_state == ALU_EXEC_IDLE;
  assign bus.rsp_valid = r_state == ALU_EXEC_DONE;
  assign bus.result    = r_result;
  assign bus.cond      = r_cond;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  assign w_long     = 1'b0;
  assign w_last     = 1'b1;
  assign w_hold_res = r_result;
`else
  logic [4:0]                r_cnt;
  logic [ALU_CTRL_WIDTH-1:0] r_op;
  logic [XLEN-1:0]           w_step;
  assign w_long     = is_shift(bus.ALUControl) && w_shamt != 5'd0;
  assign w_last     = r_cnt == 5'd1;
  assign w_step     = (r_op == ALU_CTRL_SLL) ? {r_result[XLEN-2:0], 1'b0}
                    : {(r_op == ALU_CTRL_SRA) & r_result[XLEN-1], r_result[XLEN-1:1]};
  assign w_hold_res = (r_state == ALU_EXEC_SHIFT) ? w_step : r_result;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_op  <= '0;
    end else if (w_accept) begin
      r_cnt <= w_shamt;
      r_op  <= bus.ALUControl;
    end else if (r_state == ALU_EXEC_SHIFT) begin
      r_cnt <= r_cnt - 5'd1;
    end
  end
`endif

  always_comb begin
    w_res  = '0;
    w_cond = 1'b0;
    case (bus.ALUControl)
      ALU_CTRL_ADD_ADDI, ALU_CTRL_AUIPC: w_res = bus.a + bus.b;
      ALU_CTRL_SUB:  w_res = w_diff;
      ALU_CTRL_LUI:  w_res = bus.b;
      ALU_CTRL_XOR:  w_res = bus.a ^ bus.b;
      ALU_CTRL_OR:   w_res = bus.a | bus.b;
      ALU_CTRL_AND:  w_res = bus.a & bus.b;
      ALU_CTRL_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_CTRL_SLTU: w_res = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_CTRL_MIN:  w_res = w_lt_s ? bus.a : bus.b;
      ALU_CTRL_MAX:  w_res = w_lt_s ? bus.b : bus.a;
      ALU_CTRL_MINU: w_res = w_lt_u ? bus.a : bus.b;
      ALU_CTRL_MAXU: w_res = w_lt_u ? bus.b : bus.a;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_CTRL_SLL:  w_res = bus.a << w_shamt;
      ALU_CTRL_SRL:  w_res = bus.a >> w_shamt;
      ALU_CTRL_SRA:  w_res = $signed(bus.a) >>> w_shamt;
`else
      ALU_CTRL_SLL, ALU_CTRL_SRL, ALU_CTRL_SRA: w_res = bus.a;
`endif
      ALU_CTRL_BEQ:  begin w_res = w_diff; w_cond = w_eq;    end
      ALU_CTRL_BNE:  begin w_res = w_diff; w_cond = ~w_eq;   end
      ALU_CTRL_BLT:  begin w_res = w_diff; w_cond = w_lt_s;  end
      ALU_CTRL_BGE:  begin w_res = w_diff; w_cond = ~w_lt_s; end
      ALU_CTRL_BLTU: begin w_res = w_diff; w_cond = w_lt_u;  end
      ALU_CTRL_BGEU: begin w_res = w_diff; w_cond = ~w_lt_u; end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ALU_EXEC_IDLE:  w_next = w_accept ? (w_long ? ALU_EXEC_SHIFT : ALU_EXEC_DONE) : ALU_EXEC_IDLE;
      ALU_EXEC_SHIFT: w_next = w_last ? ALU_EXEC_DONE : ALU_EXEC_SHIFT;
      ALU_EXEC_DONE:  w_next = bus.rsp_ready ? ALU_EXEC_IDLE : ALU_EXEC_DONE;
      default:        w_next = ALU_EXEC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ALU_EXEC_IDLE;
      r_result <= '0;
      r_cond   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_result <= w_long ? bus.a : w_res;
        r_cond   <= w_cond;
      end else begin
        r_result <= w_hold_res;
      end
    end
  end
endmodule

// File: tb/tb_p23_alu_exec.sv
// tb_p23_alu_exec: directed and random requests checked against an arithmetic reference model
module tb_p23_alu_exec;
  import p23_alu_exec_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  p23_alu_exec_if bus();
  p23_alu_exec dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic c);
    int signed sa, sb;
    sa = a;
    sb = b;
    r = 32'd0;
    c = 1'b0;
    case (op)
      ALU_CTRL_ADD_ADDI, ALU_CTRL_AUIPC: r = a + b;
      ALU_CTRL_SUB:  r = a - b;
      ALU_CTRL_LUI:  r = b;
      ALU_CTRL_XOR:  r = a ^ b;
      ALU_CTRL_OR:   r = a | b;
      ALU_CTRL_AND:  r = a & b;
      ALU_CTRL_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_CTRL_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_CTRL_SLL:  r = a << b[4:0];
      ALU_CTRL_SRL:  r = a >> b[4:0];
      ALU_CTRL_SRA:  r = sa >>> b[4:0];
      ALU_CTRL_MIN:  r = (sa < sb) ? a : b;
      ALU_CTRL_MAX:  r = (sa > sb) ? a : b;
      ALU_CTRL_MINU: r = (a < b) ? a : b;
      ALU_CTRL_MAXU: r = (a > b) ? a : b;
      ALU_CTRL_BEQ:  begin r = a - b; c = (a == b);  end
      ALU_CTRL_BNE:  begin r = a - b; c = (a != b);  end
      ALU_CTRL_BLT:  begin r = a - b; c = (sa < sb);  end
      ALU_CTRL_BGE:  begin r = a - b; c = (sa >= sb); end
      ALU_CTRL_BLTU: begin r = a - b; c = (a < b);   end
      ALU_CTRL_BGEU: begin r = a - b; c = (a >= b);  end
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == ALU_CTRL_SLL || op == ALU_CTRL_SRL || op == ALU_CTRL_SRA) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ec;
    int          lat;
    ref_op(op, a, b, er, ec);
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.ALUControl = op;
    bus.a          = a;
    bus.b          = b;
    @(posedge clk);
    #1;
    bus.req_valid  = (hold > 0);
    bus.ALUControl = 5'($urandom);
    bus.a          = $urandom;
    bus.b          = $urandom;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat(op, b));
    chk("result", bus.result, er);
    chk("cond", {31'd0, bus.cond}, {31'd0, ec});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", bus.result, er);
      chk("hold_cond", {31'd0, bus.cond}, {31'd0, ec});
      chk("hold_state", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd2);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("release", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic       seen;
    logic [4:0] op;
    logic [31:0] ra, rb;
    bus.req_valid  = 1'b0;
    bus.ALUControl = '0;
    bus.a          = '0;
    bus.b          = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_cond", {31'd0, bus.cond}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    resetn = 1'b1;

    do_op(ALU_CTRL_ADD_ADDI, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(ALU_CTRL_SUB, 32'd0, 32'd1, 0);
    do_op(ALU_CTRL_SRA, 32'h8000_0000, 32'd31, 0);
    do_op(ALU_CTRL_SLL, 32'h1234_5678, 32'd0, 0);
    do_op(ALU_CTRL_BLT, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(ALU_CTRL_BLTU, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(ALU_CTRL_BEQ, 32'd5, 32'd5, 0);
    do_op(ALU_CTRL_BNE, 32'd5, 32'd5, 0);
    do_op(ALU_CTRL_MIN, 32'hFFFF_FFFD, 32'd2, 0);
    do_op(ALU_CTRL_MINU, 32'hFFFF_FFFD, 32'd2, 0);
    do_op(ALU_CTRL_MAXU, 32'hFFFF_FFFD, 32'd2, 0);
    do_op(ALU_CTRL_ADD_ADDI, 32'd1234, 32'd5, 5);
    do_op(5'd31, 32'hDEAD_BEEF, 32'h1, 1);

    // reset in the middle of a long shift must abort it without a response
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.ALUControl = ALU_CTRL_SRA;
    bus.a          = 32'h8000_0000;
    bus.b          = 32'd20;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_cond", {31'd0, bus.cond}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    chk("abort_no_rsp", {31'd0, seen}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      op = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op(op, ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
